// File: rtl/ultrasonic_ctrl.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing, cm conversion and re-trigger holdoff.
// Results are published with a one-cycle data_valid_o strobe and held until the next one.
module ultrasonic_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
    parameter int unsigned PERIOD_CYCLES  = 3_000_000,
    parameter int unsigned CYC_PER_CM     = 2900,
    parameter int unsigned NEAR_CM        = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        start_i,
    input  logic        echo_i,
    output logic        trig_o,
    output logic        busy_o,
    output logic        data_valid_o,
    output logic [31:0] echo_cycles_o,
    output logic [15:0] distance_cm_o,
    output logic        timeout_o,
    output logic        near_o
);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitEcho,
        StMeasure,
        StDone,
        StHoldoff
    } state_e;

    localparam logic [15:0] NearCm = 16'(NEAR_CM);

    state_e      state_q;
    logic        echo_meta_q, echo_s_q, echo_d_q;
    logic [31:0] cnt_q;
    logic [31:0] per_cnt_q;
    logic [31:0] width_q;
    logic [31:0] presc_q;
    logic [15:0] cm_q;

    logic        rise, fall;
    logic [31:0] width_inc;

    assign rise      = echo_s_q & ~echo_d_q;
    assign fall      = ~echo_s_q & echo_d_q;
    assign width_inc = width_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            echo_meta_q   <= 1'b0;
            echo_s_q      <= 1'b0;
            echo_d_q      <= 1'b0;
            cnt_q         <= '0;
            per_cnt_q     <= '0;
            width_q       <= '0;
            presc_q       <= '0;
            cm_q          <= '0;
            trig_o        <= 1'b0;
            busy_o        <= 1'b0;
            data_valid_o  <= 1'b0;
            echo_cycles_o <= '0;
            distance_cm_o <= '0;
            timeout_o     <= 1'b0;
            near_o        <= 1'b0;
        end else begin
            echo_meta_q  <= echo_i;
            echo_s_q     <= echo_meta_q;
            echo_d_q     <= echo_s_q;
            data_valid_o <= 1'b0;
            // Period counter runs from trigger entry until the next trigger entry.
            if (state_q != StIdle) per_cnt_q <= per_cnt_q + 32'd1;

            case (state_q)
                StIdle: begin
                    if (enable_i || start_i) begin
                        state_q   <= StTrig;
                        trig_o    <= 1'b1;
                        busy_o    <= 1'b1;
                        cnt_q     <= '0;
                        per_cnt_q <= '0;
                        width_q   <= '0;
                    end
                end
                StTrig: begin
                    if (cnt_q == TRIG_CYCLES - 1) begin
                        state_q <= StWaitEcho;
                        trig_o  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StWaitEcho: begin
                    if (rise) begin
                        state_q <= StMeasure;
                        width_q <= 32'd1;
                        presc_q <= 32'd1;
                        cm_q    <= '0;
                    end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                        state_q       <= StDone;
                        data_valid_o  <= 1'b1;
                        echo_cycles_o <= width_q;
                        distance_cm_o <= 16'hFFFF;
                        timeout_o     <= 1'b1;
                        near_o        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StMeasure: begin
                    if (fall) begin
                        state_q       <= StDone;
                        data_valid_o  <= 1'b1;
                        echo_cycles_o <= width_q;
                        distance_cm_o <= cm_q;
                        timeout_o     <= 1'b0;
                        near_o        <= (cm_q < NearCm);
                    end else begin
                        width_q <= width_inc;
                        if (presc_q == CYC_PER_CM - 1) begin
                            presc_q <= '0;
                            if (cm_q != 16'hFFFF) cm_q <= cm_q + 16'd1;
                        end else begin
                            presc_q <= presc_q + 32'd1;
                        end
                        if (width_inc >= TIMEOUT_CYCLES) begin
                            state_q       <= StDone;
                            data_valid_o  <= 1'b1;
                            echo_cycles_o <= width_inc;
                            distance_cm_o <= 16'hFFFF;
                            timeout_o     <= 1'b1;
                            near_o        <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StHoldoff;
                end
                StHoldoff: begin
                    // >= covers worst-case measurements that outlast the period.
                    if (per_cnt_q >= PERIOD_CYCLES - 1) begin
                        if (enable_i) begin
                            state_q   <= StTrig;
                            trig_o    <= 1'b1;
                            cnt_q     <= '0;
                            per_cnt_q <= '0;
                            width_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    trig_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_ctrl.sv
// Directed bench for ultrasonic_ctrl using small timing overrides.
// Outputs are sampled 1 ns after the falling clock edge.
module tb_ultrasonic_ctrl;

    localparam int unsigned TrigC = 5;
    localparam int unsigned ToC   = 200;
    localparam int unsigned PerC  = 400;
    localparam int unsigned CpCm  = 10;
    localparam int unsigned NearC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        start_i = 1'b0;
    logic        echo_i = 1'b0;
    logic        trig_o, busy_o, data_valid_o, timeout_o, near_o;
    logic [31:0] echo_cycles_o;
    logic [15:0] distance_cm_o;

    ultrasonic_ctrl #(
        .TRIG_CYCLES   (TrigC),
        .TIMEOUT_CYCLES(ToC),
        .PERIOD_CYCLES (PerC),
        .CYC_PER_CM    (CpCm),
        .NEAR_CM       (NearC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .echo_i       (echo_i),
        .trig_o       (trig_o),
        .busy_o       (busy_o),
        .data_valid_o (data_valid_o),
        .echo_cycles_o(echo_cycles_o),
        .distance_cm_o(distance_cm_o),
        .timeout_o    (timeout_o),
        .near_o       (near_o)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    logic trig_p = 1'b0;
    logic busy_p = 1'b0;
    int   rise_cyc[$];
    int   trig_hi = 0;
    int   n_falls = 0;
    int   trig_fall_cyc = 0;
    int   busy_fall_cyc = 0;
    int   dv_cnt = 0;
    int   dv_cyc = 0;

    always @(negedge clk) begin
        if (trig_o && !trig_p) begin
            rise_cyc.push_back(cyc);
            trig_hi = 0;
        end
        if (trig_o) trig_hi++;
        if (!trig_o && trig_p) begin
            trig_fall_cyc = cyc;
            n_falls++;
        end
        if (!busy_o && busy_p) busy_fall_cyc = cyc;
        if (data_valid_o) begin
            dv_cnt++;
            dv_cyc = cyc;
        end
        trig_p = trig_o;
        busy_p = busy_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        int f0 = n_falls;
        int k = 0;
        while (n_falls == f0 && k < 500) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_falls != f0), 32'd1);
    endtask

    task automatic wait_dv(input string tag);
        int d0 = dv_cnt;
        int k = 0;
        while (dv_cnt == d0 && k < 500) begin
            tick(1);
            k++;
        end
        check(tag, 32'(dv_cnt - d0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy_o !== 1'b0 && k < 600) begin
            tick(1);
            k++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ec, input logic [15:0] cm,
                                input logic to, input logic nr);
        check({tag, ".echo_cycles"}, echo_cycles_o, ec);
        check({tag, ".distance_cm"}, 32'(distance_cm_o), 32'(cm));
        check({tag, ".timeout"}, 32'(timeout_o), 32'(to));
        check({tag, ".near"}, 32'(near_o), 32'(nr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".trig"}, 32'(trig_o), 32'd0);
        check({tag, ".busy"}, 32'(busy_o), 32'd0);
        check({tag, ".data_valid"}, 32'(data_valid_o), 32'd0);
        check_result(tag, 32'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int r0;
        int d0;

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy_o), 32'd0);

        // 1. Single shot, 47-cycle echo -> 4 cm, not near
        d0 = dv_cnt;
        pulse_start();
        wait_fall("t1_trig_fall");
        check("t1_trig_width", 32'(trig_hi), 32'(TrigC));
        tick(20);
        echo_i = 1'b1;
        tick(47);
        echo_i = 1'b0;
        wait_dv("t1_dv");
        check_result("t1", 32'd47, 16'd4, 1'b0, 1'b0);
        tick(1);
        check("t1_dv_one_cycle", 32'(data_valid_o), 32'd0);
        wait_idle("t1_idle");
        check("t1_busy_span", 32'(busy_fall_cyc - rise_cyc[rise_cyc.size()-1]), 32'(PerC));
        check("t1_dv_count", 32'(dv_cnt - d0), 32'd1);
        check("t1_hold", echo_cycles_o, 32'd47);

        // 2. Near object
        pulse_start();
        wait_fall("t2_trig_fall");
        tick(10);
        echo_i = 1'b1;
        tick(25);
        echo_i = 1'b0;
        wait_dv("t2_dv");
        check_result("t2", 32'd25, 16'd2, 1'b0, 1'b1);
        wait_idle("t2_idle");

        // 3. No echo -> wait timeout
        pulse_start();
        wait_fall("t3_trig_fall");
        wait_dv("t3_dv");
        check("t3_dv_latency", 32'(dv_cyc - trig_fall_cyc), 32'(ToC));
        check_result("t3", 32'd0, 16'hFFFF, 1'b1, 1'b0);
        wait_idle("t3_idle");

        // 4. Stuck echo -> width timeout
        pulse_start();
        wait_fall("t4_trig_fall");
        tick(10);
        echo_i = 1'b1;
        wait_dv("t4_dv");
        check_result("t4", ToC, 16'hFFFF, 1'b1, 1'b0);
        echo_i = 1'b0;
        wait_idle("t4_idle");

        // 5. Periodic mode with ignored start pulses
        r0 = rise_cyc.size();
        d0 = dv_cnt;
        enable_i = 1'b1;
        for (int m = 0; m < 3; m++) begin
            wait_fall("t5_trig_fall");
            tick(3);
            pulse_start();
            tick(5);
            echo_i = 1'b1;
            tick(30);
            echo_i = 1'b0;
            wait_dv("t5_dv");
            check_result("t5", 32'd30, 16'd3, 1'b0, 1'b0);
            if (m == 2) enable_i = 1'b0;
            tick(5);
            pulse_start();
        end
        wait_idle("t5_idle");
        tick(20);
        check("t5_trig_count", 32'(rise_cyc.size() - r0), 32'd3);
        check("t5_dv_count", 32'(dv_cnt - d0), 32'd3);
        check("t5_period_a", 32'(rise_cyc[r0+1] - rise_cyc[r0]), 32'(PerC));
        check("t5_period_b", 32'(rise_cyc[r0+2] - rise_cyc[r0+1]), 32'(PerC));
        check("t5_last_span", 32'(busy_fall_cyc - rise_cyc[r0+2]), 32'(PerC));
        check("t5_stays_idle", 32'(busy_o), 32'd0);

        // 6a. Stale echo high before trigger; only the second rise is measured
        echo_i = 1'b1;
        tick(5);
        pulse_start();
        wait_fall("t6_trig_fall");
        tick(10);
        echo_i = 1'b0;
        tick(10);
        echo_i = 1'b1;
        tick(35);
        echo_i = 1'b0;
        wait_dv("t6_dv");
        check_result("t6", 32'd35, 16'd3, 1'b0, 1'b0);
        wait_idle("t6_idle");

        // 6b. Asynchronous reset mid-measurement
        pulse_start();
        wait_fall("t6r_trig_fall");
        tick(5);
        echo_i = 1'b1;
        tick(10);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6r_async");
        echo_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("t6r_after_busy", 32'(busy_o), 32'd0);
        check("t6r_after_trig", 32'(trig_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
